register_bank: RTL and testbench

REGISTER_BANK -- requirements
Module: register_bank

---
 rtl/register_bank_if.sv | 37 +++
 rtl/register_bank.sv | 90 +++++++++
 tb/tb_register_bank.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/register_bank_if.sv
// register_bank_if -- request/response bundle for register_bank.
//   Parameters: WIDTH (data width), ADDR_W (address width).
//   Signals:
//     En              bank enable
//     Write, WrAddr   write request and address; in carries the write data
//     ReadA, RdAddrA  port A read request and address
//     outA, ValidA    port A registered read data and its valid flag
//     ReadB, RdAddrB  port B read request and address
//     outB, ValidB    port B registered read data and its valid flag
//   Modports: master (requester), slave (register_bank).
interface register_bank_if #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 3
);
  logic              En;
  logic              Write;
  logic [ADDR_W-1:0] WrAddr;
  logic [WIDTH-1:0]  in;
  logic              ReadA;
  logic [ADDR_W-1:0] RdAddrA;
  logic [WIDTH-1:0]  outA;
  logic              ValidA;
  logic              ReadB;
  logic [ADDR_W-1:0] RdAddrB;
  logic [WIDTH-1:0]  outB;
  logic              ValidB;

  modport master (
    output En, Write, WrAddr, in, ReadA, RdAddrA, ReadB, RdAddrB,
    input  outA, ValidA, outB, ValidB
  );

  modport slave (
    input  En, Write, WrAddr, in, ReadA, RdAddrA, ReadB, RdAddrB,
    output outA, ValidA, outB, ValidB
  );
endinterface

// File: rtl/register_bank.sv
// register_bank -- 2**ADDR_W x WIDTH register file, one write port and two
// independent registered read ports (1-cycle latency, fully pipelined).
//   Ports:
//     Clk  single clock, rising edge
//     Rst  synchronous active-high reset; clears storage and both read ports
//     bus  register_bank_if.slave (enable, write port, read ports A/B)
//   Build option:
//     REGISTER_BANK_BYPASS_EN  when defined, a read of the address written in
//                              the same cycle returns the incoming write data;
//                              otherwise it returns the pre-write contents.
module register_bank #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 3
) (
  input  logic            Clk,
  input  logic            Rst,
  register_bank_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;
  logic             valid_a_q, valid_a_d;
  logic             valid_b_q, valid_b_d;

  always_comb begin
    mem_d = mem_q;
    if (bus.En && bus.Write) begin
      mem_d[bus.WrAddr] = bus.in;
    end
  end

`ifdef REGISTER_BANK_BYPASS_EN
  // Forward the incoming write data when a read hits the word being written.
  logic hit_a, hit_b;
  assign hit_a = bus.Write && (bus.WrAddr == bus.RdAddrA);
  assign hit_b = bus.Write && (bus.WrAddr == bus.RdAddrB);
`endif

  always_comb begin
    out_a_d   = out_a_q;
    valid_a_d = 1'b0;
    if (bus.En && bus.ReadA) begin
      valid_a_d = 1'b1;
`ifdef REGISTER_BANK_BYPASS_EN
      out_a_d = hit_a ? bus.in : mem_q[bus.RdAddrA];
`else
      out_a_d = mem_q[bus.RdAddrA];
`endif
    end
  end

  always_comb begin
    out_b_d   = out_b_q;
    valid_b_d = 1'b0;
    if (bus.En && bus.ReadB) begin
      valid_b_d = 1'b1;
`ifdef REGISTER_BANK_BYPASS_EN
      out_b_d = hit_b ? bus.in : mem_q[bus.RdAddrB];
`else
      out_b_d = mem_q[bus.RdAddrB];
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      out_a_q   <= '0;
      out_b_q   <= '0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      out_a_q   <= out_a_d;
      out_b_q   <= out_b_d;
      valid_a_q <= valid_a_d;
      valid_b_q <= valid_b_d;
    end
  end

  assign bus.outA   = out_a_q;
  assign bus.ValidA = valid_a_q;
  assign bus.outB   = out_b_q;
  assign bus.ValidB = valid_b_q;
endmodule

// File: tb/tb_register_bank.sv
module tb_register_bank;
  localparam int WIDTH  = 64;
  localparam int ADDR_W = 3;
`ifdef REGISTER_BANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  register_bank_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  register_bank #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: contents and expected port outputs after each edge.
  logic [WIDTH-1:0] m_mem [8];
  logic [WIDTH-1:0] exp_a, exp_b;
  logic             exp_va, exp_vb;

  // Drive one cycle of requests, advance the model, then sample 1 time unit
  // after the rising edge.
  task automatic cycle(input logic r, input logic en,
                       input logic wr, input logic [2:0] wa, input logic [WIDTH-1:0] wd,
                       input logic ra, input logic [2:0] raa,
                       input logic rb, input logic [2:0] rba);
    rst         = r;
    bus.En      = en;
    bus.Write   = wr;
    bus.WrAddr  = wa;
    bus.in      = wd;
    bus.ReadA   = ra;
    bus.RdAddrA = raa;
    bus.ReadB   = rb;
    bus.RdAddrB = rba;
    if (r) begin
      for (int i = 0; i < 8; i++) m_mem[i] = '0;
      exp_a = '0; exp_b = '0; exp_va = 1'b0; exp_vb = 1'b0;
    end else begin
      exp_va = en && ra;
      exp_vb = en && rb;
      if (exp_va) exp_a = (BYP && wr && wa == raa) ? wd : m_mem[raa];
      if (exp_vb) exp_b = (BYP && wr && wa == rba) ? wd : m_mem[rba];
      if (en && wr) m_mem[wa] = wd;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 1, 1, 3'd0, 64'h1234, 1, 3'd0, 0, 3'd0);
    cycle(1, 0, 0, 3'd0, 64'h0, 0, 3'd0, 0, 3'd0);
    n_cmp++;
    if (bus.ValidA !== 1'b0 || bus.outA !== 64'h0) begin
      n_err++;
      $display("FAIL reset_in_reset: ValidA=%b outA=%h, required 0/0", bus.ValidA, bus.outA);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 0, 3'd0, 64'h0, 1, 3'(i), 0, 3'd0);
      n_cmp++;
      if (bus.outA !== 64'h0 || bus.ValidA !== 1'b1) begin
        n_err++;
        $display("FAIL reset_read[%0d]: outA=%h ValidA=%b, required 0/1", i, bus.outA, bus.ValidA);
      end
    end
  endtask

  task automatic test_basic();
    cycle(0, 1, 1, 3'd3, 64'h59, 0, 3'd0, 0, 3'd0);
    n_cmp++;
    if (bus.ValidA !== 1'b0) begin
      n_err++;
      $display("FAIL basic_no_read_valid: ValidA=%b, required 0", bus.ValidA);
    end
    cycle(0, 1, 0, 3'd0, 64'h0, 1, 3'd3, 0, 3'd0);
    n_cmp++;
    if (bus.outA !== 64'h59 || bus.ValidA !== 1'b1) begin
      n_err++;
      $display("FAIL basic_read: outA=%h ValidA=%b, required 59/1", bus.outA, bus.ValidA);
    end
  endtask

  task automatic test_enable();
    cycle(0, 0, 1, 3'd3, 64'hFF, 1, 3'd3, 1, 3'd3);
    n_cmp++;
    if (bus.ValidA !== 1'b0 || bus.ValidB !== 1'b0 || bus.outA !== 64'h59) begin
      n_err++;
      $display("FAIL enable_gated: ValidA=%b ValidB=%b outA=%h, required 0/0/59",
               bus.ValidA, bus.ValidB, bus.outA);
    end
    cycle(0, 1, 0, 3'd0, 64'h0, 1, 3'd3, 0, 3'd0);
    n_cmp++;
    if (bus.outA !== 64'h59 || bus.ValidA !== 1'b1) begin
      n_err++;
      $display("FAIL enable_read_after: outA=%h ValidA=%b, required 59/1", bus.outA, bus.ValidA);
    end
  endtask

  task automatic test_dual_port();
    cycle(0, 1, 1, 3'd1, 64'hA, 0, 3'd0, 0, 3'd0);
    cycle(0, 1, 1, 3'd6, 64'hB, 0, 3'd0, 0, 3'd0);
    cycle(0, 1, 0, 3'd0, 64'h0, 1, 3'd1, 1, 3'd6);
    n_cmp++;
    if (bus.outA !== 64'hA || bus.outB !== 64'hB || bus.ValidA !== 1'b1 || bus.ValidB !== 1'b1) begin
      n_err++;
      $display("FAIL dual_port: outA=%h outB=%h VA=%b VB=%b, required A/B/1/1",
               bus.outA, bus.outB, bus.ValidA, bus.ValidB);
    end
    cycle(0, 1, 0, 3'd0, 64'h0, 1, 3'd6, 1, 3'd6);
    n_cmp++;
    if (bus.outA !== 64'hB || bus.outB !== 64'hB) begin
      n_err++;
      $display("FAIL dual_same_addr: outA=%h outB=%h, required B/B", bus.outA, bus.outB);
    end
    // Write to one address while reading a different one.
    cycle(0, 1, 1, 3'd2, 64'h77, 1, 3'd6, 1, 3'd1);
    n_cmp++;
    if (bus.outA !== 64'hB || bus.outB !== 64'hA) begin
      n_err++;
      $display("FAIL wr_rd_diff_addr: outA=%h outB=%h, required B/A", bus.outA, bus.outB);
    end
  endtask

  task automatic test_collision();
    logic [WIDTH-1:0] want;
    want = BYP ? 64'hC : 64'hA;
    cycle(0, 1, 1, 3'd1, 64'hC, 1, 3'd1, 1, 3'd1);
    n_cmp++;
    if (bus.outA !== want || bus.outB !== want || bus.ValidA !== 1'b1) begin
      n_err++;
      $display("FAIL collision: outA=%h outB=%h ValidA=%b, required %h/%h/1",
               bus.outA, bus.outB, bus.ValidA, want, want);
    end
    cycle(0, 1, 0, 3'd0, 64'h0, 1, 3'd1, 0, 3'd0);
    n_cmp++;
    if (bus.outA !== 64'hC) begin
      n_err++;
      $display("FAIL collision_next_read: outA=%h, required c", bus.outA);
    end
  endtask

  task automatic test_reset_mid();
    cycle(0, 1, 1, 3'd4, 64'h4444, 1, 3'd1, 1, 3'd6);
    cycle(1, 1, 1, 3'd4, 64'hDEAD, 1, 3'd4, 1, 3'd1);
    n_cmp++;
    if (bus.ValidA !== 1'b0 || bus.outA !== 64'h0 || bus.ValidB !== 1'b0 || bus.outB !== 64'h0) begin
      n_err++;
      $display("FAIL reset_mid: VA=%b outA=%h VB=%b outB=%h, required 0/0/0/0",
               bus.ValidA, bus.outA, bus.ValidB, bus.outB);
    end
    cycle(0, 1, 0, 3'd0, 64'h0, 1, 3'd4, 1, 3'd1);
    n_cmp++;
    if (bus.outA !== 64'h0 || bus.ValidA !== 1'b1 || bus.outB !== 64'h0 || bus.ValidB !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_after: outA=%h VA=%b outB=%h VB=%b, required 0/1/0/1",
               bus.outA, bus.ValidA, bus.outB, bus.ValidB);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 1, 3'(i), 64'h100 + 64'(i), 0, 3'd0, 0, 3'd0);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 0, 3'd0, 64'h0, 1, 3'(i), 1, 3'(7 - i));
      n_cmp++;
      if (bus.outA !== 64'h100 + 64'(i) || bus.outB !== 64'h100 + 64'(7 - i) ||
          bus.ValidA !== 1'b1 || bus.ValidB !== 1'b1) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: outA=%h outB=%h VA=%b VB=%b, required %h/%h/1/1",
                 i, bus.outA, bus.outB, bus.ValidA, bus.ValidB,
                 64'h100 + 64'(i), 64'h100 + 64'(7 - i));
      end
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] wd;
    for (int n = 0; n < 400; n++) begin
      wd = {$urandom, $urandom};
      cycle(($urandom_range(31) == 0), ($urandom_range(7) != 0),
            1'($urandom), 3'($urandom), wd,
            1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom));
      n_cmp++;
      if (bus.outA !== exp_a || bus.ValidA !== exp_va || bus.outB !== exp_b || bus.ValidB !== exp_vb) begin
        n_err++;
        $display("FAIL random[%0d]: outA=%h VA=%b outB=%h VB=%b, required %h/%b/%h/%b",
                 n, bus.outA, bus.ValidA, bus.outB, bus.ValidB, exp_a, exp_va, exp_b, exp_vb);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.En = 1'b0; bus.Write = 1'b0; bus.WrAddr = '0; bus.in = '0;
    bus.ReadA = 1'b0; bus.RdAddrA = '0; bus.ReadB = 1'b0; bus.RdAddrB = '0;
    test_reset();
    test_basic();
    test_enable();
    test_dual_port();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
